// File: rtl/quick_spi_slave_pkg.sv
// Shared definitions for the quick_spi link: wire-order constants, slave FSM
// encoding and the word-reorder function used by both master and slave.
package quick_spi_slave_pkg;

    localparam bit LITTLE_ENDIAN = 1'b0;
    localparam bit BIG_ENDIAN    = 1'b1;
    localparam bit LSB_FIRST     = 1'b0;
    localparam bit MSB_FIRST     = 1'b1;

    // Widest word the reorder helper can handle.
    localparam int MAX_W = 128;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    // Maps a data word to wire order (first wire bit at [width-1]). The mapping
    // is its own inverse, so the same call turns a received shift register back
    // into a data word.
    function automatic logic [MAX_W-1:0] reorder_word(input logic [MAX_W-1:0] din,
                                                      input int width,
                                                      input bit bytes_order,
                                                      input bit bits_order);
        logic [MAX_W-1:0] dout;
        int k, j, b, t;
        dout = '0;
        for (int p = 0; p < MAX_W; p++) begin
            if (p < width) begin
                k = p / 8;
                j = p % 8;
                b = (bytes_order == BIG_ENDIAN) ? (width / 8 - 1 - k) : k;
                t = (bits_order == MSB_FIRST) ? (7 - j) : j;
                dout[width - 1 - p] = din[8 * b + t];
            end
        end
        return dout;
    endfunction

endpackage

// File: rtl/quick_spi_sync.sv
// Two-flop synchroniser for one asynchronous pin, with rise/fall strobes taken
// from the synchronised level against its previous value.
module quick_spi_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [2:0] stage_q, stage_d;

    always_comb begin
        stage_d = {stage_q[1:0], d};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stage_q <= '0;
        else          stage_q <= stage_d;
    end

    assign q    = stage_q[1];
    assign rise = stage_q[1] & ~stage_q[2];
    assign fall = ~stage_q[1] & stage_q[2];

endmodule

// File: rtl/quick_spi_slave.sv
// SPI responder: oversamples sclk/ss_n/mosi in the clk domain, deserialises
// mosi into words and serialises a word captured at frame start onto miso.
module quick_spi_slave
    import quick_spi_slave_pkg::*;
#(
    parameter int INCOMING_DATA_WIDTH = 8,
    parameter int OUTGOING_DATA_WIDTH = 8,
    parameter bit CPOL                = 1'b0,
    parameter bit CPHA                = 1'b0,
    parameter bit BYTES_ORDER         = LITTLE_ENDIAN,
    parameter bit BITS_ORDER          = LSB_FIRST
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic                           sclk,
    input  logic                           ss_n,
    input  logic                           mosi,
    output logic                           miso,
    output logic                           miso_oe,
    input  logic [OUTGOING_DATA_WIDTH-1:0] outgoing_data,
    output logic [INCOMING_DATA_WIDTH-1:0] incoming_data,
    output logic                           data_valid,
    output logic                           start_of_transaction,
    output logic                           end_of_transaction,
    output logic                           busy
);

    localparam int IW  = INCOMING_DATA_WIDTH;
    localparam int OW  = OUTGOING_DATA_WIDTH;
    localparam int RCW = $clog2(IW);
    localparam int TCW = $clog2(OW + 1);

    logic sclk_rise, sclk_fall, unused_sclk_lvl;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, unused_mosi_rise, unused_mosi_fall;

    quick_spi_sync u_sync_sclk (.clk(clk), .reset_n(reset_n), .d(sclk), .q(unused_sclk_lvl),
                                .rise(sclk_rise), .fall(sclk_fall));
    quick_spi_sync u_sync_ss   (.clk(clk), .reset_n(reset_n), .d(ss_n), .q(ss_s),
                                .rise(ss_rise), .fall(ss_fall));
    quick_spi_sync u_sync_mosi (.clk(clk), .reset_n(reset_n), .d(mosi), .q(mosi_s),
                                .rise(unused_mosi_rise), .fall(unused_mosi_fall));

    logic lead_edge, trail_edge, sample_edge, shift_edge;

    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    state_t          state_q, state_d;
    logic [OW-1:0]   tx_shift_q, tx_shift_d;
    logic [IW-1:0]   rx_shift_q, rx_shift_d, rx_next;
    logic [TCW-1:0]  tx_cnt_q, tx_cnt_d;
    logic [RCW-1:0]  rx_cnt_q, rx_cnt_d;
    logic            first_q, first_d;
    logic [IW-1:0]   incoming_q, incoming_d;
    logic            dv_q, dv_d, sot_q, sot_d, eot_q, eot_d;

    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        first_d    = first_q;
        incoming_d = incoming_q;
        dv_d       = 1'b0;
        sot_d      = 1'b0;
        eot_d      = 1'b0;
        rx_next    = {rx_shift_q[IW-2:0], mosi_s};
        case (state_q)
            WAIT_IDLE: begin
                if (ss_s) state_d = IDLE;
            end
            IDLE: begin
                if (ss_fall) begin
                    if (enable) begin
                        tx_shift_d = OW'(reorder_word(MAX_W'(outgoing_data), OW, BYTES_ORDER, BITS_ORDER));
                        tx_cnt_d   = '0;
                        rx_cnt_d   = '0;
                        first_d    = 1'b1;
                        sot_d      = 1'b1;
                        state_d    = ACTIVE;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end
            end
            ACTIVE: begin
                // Deselect wins over any coincident sclk edge or completing word.
                if (ss_rise) begin
                    eot_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = rx_next;
                        if (rx_cnt_q == RCW'(IW - 1)) begin
                            rx_cnt_d   = '0;
                            incoming_d = IW'(reorder_word(MAX_W'(rx_next), IW, BYTES_ORDER, BITS_ORDER));
                            dv_d       = 1'b1;
                        end else begin
                            rx_cnt_d = rx_cnt_q + 1'b1;
                        end
                    end
                    if (shift_edge) begin
                        // CPHA=1: the first leading edge only presents bit 0.
                        if (CPHA && first_q) begin
                            first_d = 1'b0;
                        end else if (tx_cnt_q != TCW'(OW)) begin
                            tx_shift_d = {tx_shift_q[OW-2:0], 1'b0};
                            tx_cnt_d   = tx_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= WAIT_IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            first_q    <= 1'b0;
            incoming_q <= '0;
            dv_q       <= 1'b0;
            sot_q      <= 1'b0;
            eot_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            first_q    <= first_d;
            incoming_q <= incoming_d;
            dv_q       <= dv_d;
            sot_q      <= sot_d;
            eot_q      <= eot_d;
        end
    end

    assign busy                 = (state_q == ACTIVE);
    assign miso_oe              = busy;
    assign miso                 = (busy && (tx_cnt_q != TCW'(OW))) ? tx_shift_q[OW-1] : 1'b0;
    assign incoming_data        = incoming_q;
    assign data_valid           = dv_q;
    assign start_of_transaction = sot_q;
    assign end_of_transaction   = eot_q;

endmodule

// File: tb/tb_quick_spi_slave.sv
// Drives five differently configured slaves as an SPI master and checks
// received words, miso bit streams and frame pulses against a byte-queue model.
`timescale 1ns/1ps
module tb_quick_spi_slave;

    localparam int NDUT = 5;
    localparam int HALF = 8;
    localparam int IW_T   [NDUT] = '{16, 16, 8, 8, 8};
    localparam int OW_T   [NDUT] = '{8, 16, 8, 8, 8};
    localparam bit CPOL_T [NDUT] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam bit CPHA_T [NDUT] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam bit BE_T   [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam bit MSB_T  [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    typedef bit bitq_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b1;
    logic [NDUT-1:0] sclk_v, ss_v, mosi_v;
    wire  [NDUT-1:0] miso_v, oe_v, dv_v, sot_v, eot_v, busy_v;
    wire  [15:0]     inc_w [NDUT];
    logic [15:0]     out_word [NDUT];
    logic [15:0]     exp_inc [NDUT];
    int dv_cnt [NDUT];
    int sot_cnt [NDUT];
    int eot_cnt [NDUT];
    int n_chk = 0;
    int n_err = 0;
    logic mid_busy, mid_oe;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int IW = IW_T[g];
        localparam int OW = OW_T[g];
        logic [IW-1:0] inc;
        logic [OW-1:0] od;
        assign od       = out_word[g][OW-1:0];
        assign inc_w[g] = 16'(inc);
        quick_spi_slave #(
            .INCOMING_DATA_WIDTH(IW), .OUTGOING_DATA_WIDTH(OW),
            .CPOL(CPOL_T[g]), .CPHA(CPHA_T[g]),
            .BYTES_ORDER(BE_T[g]), .BITS_ORDER(MSB_T[g])
        ) u_dut (
            .clk(clk), .reset_n(rst_n), .enable(enable),
            .sclk(sclk_v[g]), .ss_n(ss_v[g]), .mosi(mosi_v[g]),
            .miso(miso_v[g]), .miso_oe(oe_v[g]),
            .outgoing_data(od), .incoming_data(inc),
            .data_valid(dv_v[g]), .start_of_transaction(sot_v[g]),
            .end_of_transaction(eot_v[g]), .busy(busy_v[g])
        );
    end

    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (dv_v[i])  dv_cnt[i]++;
            if (sot_v[i]) sot_cnt[i]++;
            if (eot_v[i]) eot_cnt[i]++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wire order of a word: split into bytes, order them, then walk each byte.
    function automatic bitq_t to_wire(input logic [15:0] w, input int width, input bit be, input bit msb);
        logic [7:0] bytes[$];
        bitq_t q;
        for (int i = 0; i < width / 8; i++) begin
            if (be) bytes.push_front(w[8*i +: 8]);
            else    bytes.push_back(w[8*i +: 8]);
        end
        foreach (bytes[k])
            for (int b = 0; b < 8; b++) q.push_back(msb ? bytes[k][7-b] : bytes[k][b]);
        return q;
    endfunction

    function automatic bitq_t from_lit(input logic [63:0] v, input int n);
        bitq_t q;
        for (int i = 0; i < n; i++) q.push_back(v[n-1-i]);
        return q;
    endfunction

    function automatic logic [63:0] pack(input bitq_t q);
        logic [63:0] r;
        r = '0;
        foreach (q[i]) r = {r[62:0], q[i]};
        return r;
    endfunction

    task automatic xfer(input int d, input bitq_t mo, output bitq_t mi);
        mi = {};
        ss_v[d] = 1'b0;
        repeat (HALF) @(negedge clk);
        mid_busy = busy_v[d];
        mid_oe   = oe_v[d];
        foreach (mo[i]) begin
            if (!CPHA_T[d]) begin
                mosi_v[d] = mo[i];
                repeat (2) @(negedge clk);
                mi.push_back(bit'(miso_v[d]));
                sclk_v[d] = ~CPOL_T[d];
                repeat (HALF) @(negedge clk);
                sclk_v[d] = CPOL_T[d];
                repeat (HALF - 2) @(negedge clk);
            end else begin
                sclk_v[d] = ~CPOL_T[d];
                mosi_v[d] = mo[i];
                repeat (HALF) @(negedge clk);
                mi.push_back(bit'(miso_v[d]));
                sclk_v[d] = CPOL_T[d];
                repeat (HALF) @(negedge clk);
            end
        end
        repeat (2) @(negedge clk);
        ss_v[d]   = 1'b1;
        mosi_v[d] = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic frame(input int d, input bitq_t mo, input int nw, input logic [15:0] last,
                         input bitq_t em);
        bitq_t mi;
        int dv0 = dv_cnt[d];
        int s0  = sot_cnt[d];
        int e0  = eot_cnt[d];
        string tg = $sformatf("dut%0d", d);
        xfer(d, mo, mi);
        if (nw > 0) exp_inc[d] = last;
        chk({tg, "_rx_word"},   inc_w[d], exp_inc[d]);
        chk({tg, "_dv_pulses"}, dv_cnt[d] - dv0, nw);
        chk({tg, "_sot"},       sot_cnt[d] - s0, 1);
        chk({tg, "_eot"},       eot_cnt[d] - e0, 1);
        chk({tg, "_mid_busy"},  mid_busy, 1);
        chk({tg, "_mid_oe"},    mid_oe, 1);
        chk({tg, "_post_oe"},   oe_v[d], 0);
        chk({tg, "_post_busy"}, busy_v[d], 0);
        chk({tg, "_miso"},      pack(mi), pack(em));
    endtask

    task automatic std_frame(input int d, input int nw, input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] tx, input int extra);
        bitq_t mo, em, t;
        logic [15:0] last;
        mo = {};
        if (nw > 0) mo = to_wire(w0, IW_T[d], BE_T[d], MSB_T[d]);
        if (nw > 1) begin
            t = to_wire(w1, IW_T[d], BE_T[d], MSB_T[d]);
            foreach (t[i]) mo.push_back(t[i]);
        end
        repeat (extra) mo.push_back(bit'($urandom_range(0, 1)));
        out_word[d] = tx;
        t  = to_wire(tx, OW_T[d], BE_T[d], MSB_T[d]);
        em = {};
        foreach (mo[i]) em.push_back((i < OW_T[d]) ? t[i] : 1'b0);
        last = (nw > 1) ? w1 : w0;
        if (IW_T[d] == 8) last = last & 16'h00FF;
        frame(d, mo, nw, last, em);
    endtask

    initial begin
        bitq_t mi;
        int d, s0, e0, dv0;
        for (int i = 0; i < NDUT; i++) begin
            sclk_v[i]   = CPOL_T[i];
            out_word[i] = '0;
            exp_inc[i]  = '0;
        end
        ss_v   = '1;
        mosi_v = '0;
        rst_n  = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_ctrl", {busy_v, oe_v, miso_v, dv_v, sot_v, eot_v}, 0);
        for (int i = 0; i < NDUT; i++) chk($sformatf("rst_rx%0d", i), inc_w[i], 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Fixed wire patterns: BE/MSB 16-bit receive with 8-bit 0x95 transmit, then LE/LSB.
        out_word[0] = 16'h0095;
        frame(0, from_lit(64'hCC82, 16), 1, 16'hCC82, from_lit(64'h9500, 16));
        out_word[1] = 16'h1234;
        frame(1, from_lit(64'h4133, 16), 1, 16'hCC82, to_wire(16'h1234, 16, 1'b0, 1'b0));

        for (int i = 0; i < NDUT; i++) std_frame(i, 1, 16'h00A5, 16'h0000, 16'h003C, 0);

        // Aborted 5-bit frame keeps the old word, next full frame delivers.
        std_frame(2, 0, 16'h0000, 16'h0000, 16'h00AA, 5);
        std_frame(2, 1, 16'h0081, 16'h0000, 16'h0055, 0);

        // Reset mid-frame with ss_n held low: slave must stay quiet until ss_n cycles.
        ss_v[0] = 1'b0;
        repeat (HALF) @(negedge clk);
        repeat (3) begin
            sclk_v[0] = 1'b1; mosi_v[0] = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk_v[0] = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_busy", busy_v[0], 0);
        chk("midrst_oe", oe_v[0], 0);
        chk("midrst_rx", inc_w[0], 0);
        for (int i = 0; i < NDUT; i++) exp_inc[i] = '0;
        rst_n = 1'b1;
        s0  = sot_cnt[0];
        dv0 = dv_cnt[0];
        repeat (16) begin
            sclk_v[0] = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk_v[0] = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        chk("postrst_sot", sot_cnt[0] - s0, 0);
        chk("postrst_dv", dv_cnt[0] - dv0, 0);
        chk("postrst_busy", busy_v[0], 0);
        ss_v[0] = 1'b1; mosi_v[0] = 1'b0;
        repeat (HALF) @(negedge clk);
        std_frame(0, 1, 16'h5AC3, 16'h0000, 16'h00E7, 0);

        // enable low at frame start: frame ignored entirely.
        enable = 1'b0;
        s0  = sot_cnt[3];
        e0  = eot_cnt[3];
        dv0 = dv_cnt[3];
        xfer(3, to_wire(16'h00C3, 8, 1'b0, 1'b0), mi);
        chk("en0_busy", mid_busy, 0);
        chk("en0_oe", mid_oe, 0);
        chk("en0_sot", sot_cnt[3] - s0, 0);
        chk("en0_eot", eot_cnt[3] - e0, 0);
        chk("en0_dv", dv_cnt[3] - dv0, 0);
        chk("en0_rx", inc_w[3], exp_inc[3]);
        enable = 1'b1;
        std_frame(3, 1, 16'h0042, 16'h0000, 16'h0099, 0);

        for (int n = 0; n < 16; n++) begin
            d = $urandom_range(0, NDUT - 1);
            std_frame(d, $urandom_range(1, 2), 16'($urandom), 16'($urandom), 16'($urandom),
                      $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
